// File: rtl/cgra_pkg.sv
// rtl/cgra_pkg.sv - shared types for the CGRA kernel scheduler
// Contents: scheduler FSM state enum, launch FIFO entry struct, default field widths.
package cgra_pkg;

  // Default field widths; the scheduler parameters default to these so the
  // FIFO entry layout lines up with the host-facing ports.
  localparam int KSCHED_N_COL    = 4;
  localparam int KSCHED_N_SLOTS  = 4;
  localparam int KSCHED_KER_ID_W = 4;
  localparam int KSCHED_NCOL_W   = $clog2(KSCHED_N_COL) + 1;
  localparam int KSCHED_SLOT_W   = $clog2(KSCHED_N_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_REQ   = 2'd2
  } ksched_state_e;

  typedef struct packed {
    logic [KSCHED_KER_ID_W-1:0] ker_id;
    logic [KSCHED_NCOL_W-1:0]   ncol;
    logic [KSCHED_SLOT_W-1:0]   slot;
  } ksched_entry_t;

endpackage

// File: rtl/cgra_kernel_scheduler_if.sv
// rtl/cgra_kernel_scheduler_if.sv - host launch / controller handshake bundle
// slave modport (scheduler side):
//   in : sub_valid_i, sub_ker_id_i, sub_ncol_i, sub_slot_i, acc_ack_i, acc_end_i
//   out: sub_ready_o, acc_req_o, ker_id_o, col_busy_o, q_count_o, evt_o, err_o
// master modport is the mirror image (host + controller side).
interface cgra_kernel_scheduler_if
  import cgra_pkg::*;
#(
  parameter int N_COL       = KSCHED_N_COL,
  parameter int N_SLOTS     = KSCHED_N_SLOTS,
  parameter int KER_ID_W    = KSCHED_KER_ID_W,
  parameter int QUEUE_DEPTH = 4
);
  localparam int NCOL_W = $clog2(N_COL) + 1;
  localparam int SLOT_W = $clog2(N_SLOTS);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;

  logic                sub_valid_i;
  logic                sub_ready_o;
  logic [KER_ID_W-1:0] sub_ker_id_i;
  logic [NCOL_W-1:0]   sub_ncol_i;
  logic [SLOT_W-1:0]   sub_slot_i;
  logic [N_COL-1:0]    acc_req_o;
  logic [KER_ID_W-1:0] ker_id_o;
  logic                acc_ack_i;
  logic [N_COL-1:0]    acc_end_i;
  logic [N_COL-1:0]    col_busy_o;
  logic [CNT_W-1:0]    q_count_o;
  logic [N_SLOTS-1:0]  evt_o;
  logic                err_o;

  modport slave (
    input  sub_valid_i, sub_ker_id_i, sub_ncol_i, sub_slot_i, acc_ack_i, acc_end_i,
    output sub_ready_o, acc_req_o, ker_id_o, col_busy_o, q_count_o, evt_o, err_o
  );

  modport master (
    output sub_valid_i, sub_ker_id_i, sub_ncol_i, sub_slot_i, acc_ack_i, acc_end_i,
    input  sub_ready_o, acc_req_o, ker_id_o, col_busy_o, q_count_o, evt_o, err_o
  );

endinterface

// File: rtl/cgra_ksched_fifo.sv
// rtl/cgra_ksched_fifo.sv - launch FIFO for the kernel scheduler
// Ports: clk_i, rst_ni (async active-low); push/push_data write side;
//        pop/head read side (head is the oldest entry, valid when !empty);
//        empty, full, count occupancy status.
module cgra_ksched_fifo
  import cgra_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  ksched_entry_t push_data,
  input  logic          pop,
  output ksched_entry_t head,
  output logic          empty,
  output logic          full,
  output logic [CNT_W-1:0] count
);

  ksched_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;

endmodule

// File: rtl/cgra_kernel_scheduler.sv
// rtl/cgra_kernel_scheduler.sv - in-order kernel launcher onto contiguous CGRA columns
// Ports: clk_i, rst_ni (async active-low); bus (cgra_kernel_scheduler_if.slave):
//   host launch handshake, per-column controller request/ack/end, column busy map,
//   FIFO occupancy, per-slot completion events and illegal-ncol error pulse.
// Optional: CGRA_KSCHED_PERF_EN adds wait_cycles_o, a saturating count of
//   cycles spent in ALLOC without finding room for the head launch.
module cgra_kernel_scheduler
  import cgra_pkg::*;
#(
  parameter int N_COL       = KSCHED_N_COL,
  parameter int N_SLOTS     = KSCHED_N_SLOTS,
  parameter int KER_ID_W    = KSCHED_KER_ID_W,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  cgra_kernel_scheduler_if.slave bus
`ifdef CGRA_KSCHED_PERF_EN
  ,
  output logic [31:0] wait_cycles_o
`endif
);

  localparam int NCOL_W = $clog2(N_COL) + 1;
  localparam int SLOT_W = $clog2(N_SLOTS);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int OUT_W  = $clog2(N_COL) + 1;

  ksched_state_e    state_q, state_d;
  ksched_entry_t    push_entry, head;
  logic             fifo_empty, fifo_full, push, ack, ncol_legal;
  logic [CNT_W-1:0] fifo_count;

  logic [N_COL-1:0]   busy_q, busy_d;
  logic [N_COL-1:0]   mask_q, alloc_mask;
  logic               alloc_found;
  logic [SLOT_W-1:0]  col_slot_q [N_COL];
  logic [OUT_W-1:0]   out_cnt_q [N_SLOTS];
  logic [OUT_W-1:0]   out_cnt_d [N_SLOTS];
  logic [N_SLOTS-1:0] evt_q, evt_d;
  logic               err_q;

  // Illegal requests still complete the handshake (ready is only !full) but
  // never reach the FIFO.
  assign ncol_legal = (bus.sub_ncol_i != '0) && (bus.sub_ncol_i <= NCOL_W'(N_COL));
  assign push       = bus.sub_valid_i && !fifo_full && ncol_legal;
  assign push_entry = '{ker_id: bus.sub_ker_id_i, ncol: bus.sub_ncol_i, slot: bus.sub_slot_i};
  assign ack        = (state_q == ST_REQ) && bus.acc_ack_i;

  cgra_ksched_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (push_entry),
    .pop       (ack),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Lowest-index run of head.ncol free columns. Scanning starts from the top
  // so the last hit, i.e. the lowest start, is the one kept.
  always_comb begin
    logic [N_COL-1:0] run;
    alloc_found = 1'b0;
    alloc_mask  = '0;
    run         = '0;
    for (int s = N_COL - 1; s >= 0; s--) begin
      run = '0;
      for (int c = 0; c < N_COL; c++) begin
        if (c >= s && c < s + int'(head.ncol)) run[c] = 1'b1;
      end
      if ((s + int'(head.ncol) <= N_COL) && ((run & busy_q) == '0)) begin
        alloc_found = 1'b1;
        alloc_mask  = run;
      end
    end
  end

  // FSM next state and request outputs.
  always_comb begin
    state_d       = state_q;
    bus.acc_req_o = '0;
    bus.ker_id_o  = '0;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ALLOC;
      // No bypass: a head that does not fit blocks everything behind it.
      ST_ALLOC: if (alloc_found) state_d = ST_REQ;
      ST_REQ: begin
        bus.acc_req_o = mask_q;
        bus.ker_id_o  = KER_ID_W'(head.ker_id);
        if (bus.acc_ack_i) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Column map and per-slot outstanding-column counters. Ends only touch
  // columns already busy, and an acked mask is always disjoint from busy_q,
  // so both updates apply independently in the same cycle.
  always_comb begin
    logic [OUT_W-1:0] mask_pop;
    logic [OUT_W-1:0] inc;
    logic [OUT_W-1:0] dec;
    busy_d   = busy_q;
    mask_pop = '0;
    inc      = '0;
    dec      = '0;
    evt_d    = '0;
    for (int c = 0; c < N_COL; c++) begin
      mask_pop = mask_pop + OUT_W'(mask_q[c]);
      if (bus.acc_end_i[c] && busy_q[c]) busy_d[c] = 1'b0;
    end
    if (ack) busy_d = busy_d | mask_q;
    for (int s = 0; s < N_SLOTS; s++) begin
      inc = '0;
      dec = '0;
      if (ack && (head.slot == SLOT_W'(s))) inc = mask_pop;
      for (int c = 0; c < N_COL; c++) begin
        if (bus.acc_end_i[c] && busy_q[c] && (col_slot_q[c] == SLOT_W'(s))) dec = dec + 1'b1;
      end
      out_cnt_d[s] = out_cnt_q[s] + inc - dec;
      evt_d[s]     = (out_cnt_q[s] != '0) && (out_cnt_d[s] == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      busy_q  <= '0;
      mask_q  <= '0;
      evt_q   <= '0;
      err_q   <= 1'b0;
      for (int c = 0; c < N_COL; c++) col_slot_q[c] <= '0;
      for (int s = 0; s < N_SLOTS; s++) out_cnt_q[s] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
      err_q   <= bus.sub_valid_i && !fifo_full && !ncol_legal;
      if (state_q == ST_ALLOC && alloc_found) mask_q <= alloc_mask;
      if (ack) begin
        for (int c = 0; c < N_COL; c++) begin
          if (mask_q[c]) col_slot_q[c] <= head.slot;
        end
      end
      for (int s = 0; s < N_SLOTS; s++) out_cnt_q[s] <= out_cnt_d[s];
    end
  end

  assign bus.sub_ready_o = !fifo_full;
  assign bus.q_count_o   = fifo_count;
  assign bus.col_busy_o  = busy_q;
  assign bus.evt_o       = evt_q;
  assign bus.err_o       = err_q;

`ifdef CGRA_KSCHED_PERF_EN
  logic [31:0] wait_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else if (state_q == ST_ALLOC && !alloc_found && wait_q != '1) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign wait_cycles_o = wait_q;
`endif

endmodule

// File: tb/tb_cgra_kernel_scheduler.sv
// tb/tb_cgra_kernel_scheduler.sv - scoreboard bench for cgra_kernel_scheduler
module tb_cgra_kernel_scheduler;

  localparam int N_COL = 4;
  localparam int N_SLOTS = 4;
  localparam int KER_ID_W = 4;
  localparam int QD = 4;

  typedef struct { int ker; int ncol; int slot; } launch_t;
  typedef struct { int stamp; logic [N_SLOTS-1:0] val; } evt_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  cgra_kernel_scheduler_if #(.N_COL(N_COL), .N_SLOTS(N_SLOTS), .KER_ID_W(KER_ID_W),
                             .QUEUE_DEPTH(QD)) bus ();
`ifdef CGRA_KSCHED_PERF_EN
  logic [31:0] wait_cycles;
`endif

  cgra_kernel_scheduler #(.N_COL(N_COL), .N_SLOTS(N_SLOTS), .KER_ID_W(KER_ID_W),
                          .QUEUE_DEPTH(QD)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
`ifdef CGRA_KSCHED_PERF_EN
    ,
    .wait_cycles_o (wait_cycles)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  launch_t          exp_launch_q[$];
  evt_t             exp_evt_q[$];
  int               exp_err_q[$];
  logic [N_COL-1:0] model_busy = '0;
  logic [N_COL-1:0] prev_busy = '0;
  int               model_col_slot[N_COL];
  int               model_cnt[N_SLOTS];
  int               model_qcount = 0;
  bit               req_seen = 0;
  logic [N_COL-1:0] cur_mask = '0;
  launch_t          cur_launch;
  int               ctl_mode = 1;   // 0 random, 1 hold, 2 drain, 3 ack-only
  logic [N_COL-1:0] man_end = '0;
  bit               mon_en = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lowest-start window of ncol free columns, or 0 when none exists.
  function automatic logic [N_COL-1:0] ref_alloc(input logic [N_COL-1:0] busy, input int ncol);
    for (int start = 0; start + ncol <= N_COL; start++) begin
      bit ok = 1;
      for (int k = 0; k < ncol; k++) if (busy[start + k]) ok = 0;
      if (ok) return N_COL'(((1 << ncol) - 1) << start);
    end
    return '0;
  endfunction

  // Monitor: compares DUT outputs against the model / scoreboard queues.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("col_busy", bus.col_busy_o, model_busy);
        check("q_count", bus.q_count_o, model_qcount);
        check("sub_ready", bus.sub_ready_o, int'(model_qcount < QD));
        if (bus.acc_req_o != '0) begin
          if (!req_seen) begin
            if (exp_launch_q.size() == 0) begin
              check("acc_req_unexpected", bus.acc_req_o, 0);
            end else begin
              cur_launch = exp_launch_q.pop_front();
              cur_mask = ref_alloc(prev_busy, cur_launch.ncol);
              check("acc_req", bus.acc_req_o, cur_mask);
              check("ker_id", bus.ker_id_o, cur_launch.ker);
              req_seen = 1;
            end
          end else begin
            check("acc_req_hold", bus.acc_req_o, cur_mask);
          end
        end else if (req_seen) begin
          check("acc_req_hold", bus.acc_req_o, cur_mask);
        end
        if (bus.evt_o != '0) begin
          if (exp_evt_q.size() == 0) begin
            check("evt_unexpected", bus.evt_o, 0);
          end else begin
            e = exp_evt_q.pop_front();
            check("evt", bus.evt_o, e.val);
            check("evt_cycle", cyc, e.stamp);
          end
        end
        while (exp_evt_q.size() > 0 && exp_evt_q[0].stamp < cyc) begin
          e = exp_evt_q.pop_front();
          check("evt_missing", 0, e.val);
        end
        if (bus.err_o) begin
          if (exp_err_q.size() == 0) check("err_unexpected", 1, 0);
          else check("err_cycle", cyc, exp_err_q.pop_front());
        end
        while (exp_err_q.size() > 0 && exp_err_q[0] < cyc) begin
          void'(exp_err_q.pop_front());
          check("err_missing", 0, 1);
        end
      end
    end
  end

  // Controller model: drives ack / end and predicts busy map and events.
  initial begin
    logic [N_COL-1:0]   ends;
    logic [N_SLOTS-1:0] ev;
    bit                 ack;
    int                 old_cnt[N_SLOTS];
    int                 c;
    bus.acc_ack_i = 1'b0;
    bus.acc_end_i = '0;
    forever begin
      @(negedge clk);
      #1;
      ends = '0;
      ack = 0;
      case (ctl_mode)
        0: begin
          for (int i = 0; i < N_COL; i++) if (model_busy[i] && $urandom_range(0, 3) == 0) ends[i] = 1'b1;
          if (req_seen && $urandom_range(0, 1) == 1) ack = 1;
          if ($urandom_range(0, 7) == 0) begin
            c = $urandom_range(0, N_COL - 1);
            if (!model_busy[c] && !(ack && cur_mask[c])) ends[c] = 1'b1;
          end
        end
        2: begin
          ends = model_busy;
          ack = req_seen;
        end
        default: begin
          ends = man_end;
          man_end = '0;
          ack = (ctl_mode == 3) && req_seen;
        end
      endcase
      old_cnt = model_cnt;
      prev_busy = model_busy;
      for (int i = 0; i < N_COL; i++) begin
        if (ends[i] && model_busy[i]) begin
          model_busy[i] = 1'b0;
          model_cnt[model_col_slot[i]]--;
        end
      end
      if (ack) begin
        for (int i = 0; i < N_COL; i++) begin
          if (cur_mask[i]) begin
            model_busy[i] = 1'b1;
            model_col_slot[i] = cur_launch.slot;
            model_cnt[cur_launch.slot]++;
          end
        end
        model_qcount--;
        req_seen = 0;
      end
      ev = '0;
      for (int s = 0; s < N_SLOTS; s++) if (old_cnt[s] != 0 && model_cnt[s] == 0) ev[s] = 1'b1;
      if (ev != '0) exp_evt_q.push_back('{cyc + 1, ev});
      bus.acc_ack_i = ack;
      bus.acc_end_i = ends;
    end
  end

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic submit(input int ker, input int ncol, input int slot);
    int waitc = 0;
    bus.sub_valid_i = 1'b1;
    bus.sub_ker_id_i = KER_ID_W'(ker);
    bus.sub_ncol_i = 3'(ncol);
    bus.sub_slot_i = 2'(slot);
    while (!bus.sub_ready_o && waitc < 300) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!bus.sub_ready_o) begin
      check("submit_timeout", 0, 1);
    end else begin
      if (ncol >= 1 && ncol <= N_COL) begin
        exp_launch_q.push_back('{ker, ncol, slot});
        model_qcount++;
      end else begin
        exp_err_q.push_back(cyc + 1);
      end
      @(negedge clk);
      #1;
    end
    bus.sub_valid_i = 1'b0;
  endtask

  function automatic bit cond_met(input int kind);
    case (kind)
      0: return model_qcount == 0 && model_busy == '0 && !req_seen && exp_evt_q.size() == 0;
      1: return req_seen;
      default: return model_qcount == 0 && !req_seen;
    endcase
  endfunction

  task automatic wait_for(input int kind, input string name);
    int n = 0;
    while (!cond_met(kind) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cond_met(kind)) check(name, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int r;
    int nc;
    for (int i = 0; i < N_SLOTS; i++) model_cnt[i] = 0;
    for (int i = 0; i < N_COL; i++) model_col_slot[i] = 0;
    bus.sub_valid_i = 1'b0;
    bus.sub_ker_id_i = '0;
    bus.sub_ncol_i = '0;
    bus.sub_slot_i = '0;
    #12;
    check("rst_acc_req", bus.acc_req_o, 0);
    check("rst_ker_id", bus.ker_id_o, 0);
    check("rst_col_busy", bus.col_busy_o, 0);
    check("rst_q_count", bus.q_count_o, 0);
    check("rst_sub_ready", bus.sub_ready_o, 1);
    check("rst_evt", bus.evt_o, 0);
    check("rst_err", bus.err_o, 0);
    @(negedge clk);
    #1;
    rst_ni = 1'b1;
    mon_en = 1;

    // Single launch through to its completion event.
    ctl_mode = 2;
    idle(2);
    submit(3, 2, 1);
    wait_for(0, "drain_basic");

    // Head waits for a contiguous window; no bypass.
    ctl_mode = 3;
    submit(1, 2, 0);
    wait_for(2, "ack_first");
    submit(2, 3, 1);
    idle(6);
    check("alloc_hold", bus.acc_req_o, 0);
    man_end = 4'b0001;
    idle(5);
    check("alloc_hold_partial", bus.acc_req_o, 0);
    man_end = 4'b0010;
    wait_for(2, "ack_second");
    ctl_mode = 2;
    wait_for(0, "drain_alloc");

    // Two slots completing together.
    ctl_mode = 3;
    submit(4, 2, 0);
    submit(5, 1, 2);
    wait_for(2, "ack_pair");
    idle(2);
    man_end = 4'b0111;
    idle(3);
    ctl_mode = 2;
    wait_for(0, "drain_pair");

    // Illegal column counts.
    submit(6, 0, 0);
    submit(7, 5, 0);
    idle(3);
    wait_for(0, "drain_err");

    // Fill the FIFO while acks are withheld.
    ctl_mode = 1;
    for (int i = 0; i < QD; i++) submit(8 + i, $urandom_range(1, N_COL), i % N_SLOTS);
    check("full_ready", bus.sub_ready_o, 0);
    check("full_count", bus.q_count_o, QD);
    ctl_mode = 2;
    submit(12, $urandom_range(1, N_COL), 3);
    wait_for(0, "drain_full");

    // Randomized traffic.
    ctl_mode = 0;
    for (int i = 0; i < 80; i++) begin
      idle($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      nc = (r == 0) ? 0 : (r == 1) ? 5 : $urandom_range(1, N_COL);
      submit($urandom_range(0, 15), nc, $urandom_range(0, N_SLOTS - 1));
    end
    ctl_mode = 2;
    wait_for(0, "drain_random");
    idle(3);

    // Reset while a launch is pending and two more are queued.
    ctl_mode = 1;
    submit(13, 2, 0);
    submit(14, 1, 1);
    submit(15, 3, 2);
    wait_for(1, "req_before_reset");
    #2;
    mon_en = 0;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_acc_req", bus.acc_req_o, 0);
    check("mid_rst_ker_id", bus.ker_id_o, 0);
    check("mid_rst_col_busy", bus.col_busy_o, 0);
    check("mid_rst_q_count", bus.q_count_o, 0);
    check("mid_rst_sub_ready", bus.sub_ready_o, 1);
    check("mid_rst_evt", bus.evt_o, 0);
    check("mid_rst_err", bus.err_o, 0);
    exp_launch_q.delete();
    exp_evt_q.delete();
    exp_err_q.delete();
    model_busy = '0;
    prev_busy = '0;
    model_qcount = 0;
    req_seen = 0;
    for (int i = 0; i < N_SLOTS; i++) model_cnt[i] = 0;
    @(negedge clk);
    #1;
    rst_ni = 1'b1;
    mon_en = 1;
    idle(20);
    ctl_mode = 2;
    submit(9, 4, 3);
    wait_for(0, "drain_after_reset");
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cgra_kernel_scheduler.md
CGRA_KERNEL_SCHEDULER -- requirements
Module: cgra_kernel_scheduler

Interface
REQ-001: Parameter N_COL, default 4, number of CGRA columns scheduled.
REQ-002: Parameter N_SLOTS, default 4, number of host launch slots / event lines.
REQ-003: Parameter KER_ID_W, default 4, kernel-id width.
REQ-004: Parameter QUEUE_DEPTH, default 4, launch FIFO entries (power of two).
REQ-005: clk_i  in  1  clock; reset rst_ni, asynchronous, active-low.
REQ-006: rst_ni  in  1  asynchronous active-low reset.
REQ-007: sub_valid_i  in  1  launch request valid.
REQ-008: sub_ready_o  out  1  FIFO can accept a launch.
REQ-009: sub_ker_id_i  in  KER_ID_W  kernel id to launch.
REQ-010: sub_ncol_i  in  $clog2(N_COL)+1  columns requested, legal 1..N_COL.
REQ-011: sub_slot_i  in  $clog2(N_SLOTS)  slot that receives the completion event.
REQ-012: acc_req_o  out  N_COL  per-column launch request to cgra_controller.
REQ-013: ker_id_o  out  KER_ID_W  kernel id of the pending launch.
REQ-014: acc_ack_i  in  1  controller accepted the launch.
REQ-015: acc_end_i  in  N_COL  per-column end-of-kernel pulse.
REQ-016: col_busy_o  out  N_COL  column allocated to a running kernel.
REQ-017: q_count_o  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy.
REQ-018: evt_o  out  N_SLOTS  one-cycle completion pulse per slot.
REQ-019: err_o  out  1  one-cycle pulse on an illegal sub_ncol_i (0 or >N_COL).

Function
REQ-020: A launch is accepted on sub_valid_i & sub_ready_o; sub_ready_o = !full; an illegal ncol pulses err_o and is dropped, not queued.
REQ-021: The FSM has states IDLE, ALLOC, REQ, with transitions as follows.
REQ-022: IDLE->ALLOC when the FIFO is non-empty.
REQ-023: In ALLOC, the scheduler picks the lowest-index contiguous run of head.ncol free columns; if one exists it latches the mask and goes to REQ, otherwise it stays in ALLOC with no bypass (strict FIFO order).
REQ-024: In REQ, acc_req_o = mask and ker_id_o = head.ker_id are held until acc_ack_i. On ack: pop FIFO, set col_busy for mask, record slot per column, go to IDLE; latency from push into empty FIFO with free columns to acc_req_o is 2 cycles.
REQ-025: acc_end_i[c] with col_busy_o[c] clears that bit next cycle; acc_end_i on a non-busy column is ignored.
REQ-026: A per-slot outstanding-column counter is incremented by popcount(mask) on ack and decremented by popcount of matching ends. evt_o[s] pulses the cycle after it reaches 0.
REQ-027: Simultaneous ack and end on different columns are both applied; simultaneous push and pop keep q_count_o unchanged.
REQ-028: Push when full is impossible (ready low); pop only on ack, never when empty; FIFO pointers wrap modulo QUEUE_DEPTH.
REQ-029: Multiple slots may complete in the same cycle; all corresponding evt_o bits pulse together.

Reset
REQ-030: On reset: FSM=IDLE, FIFO empty, q_count_o=0, sub_ready_o=1, acc_req_o=0, ker_id_o=0, col_busy_o=0, evt_o=0, err_o=0, slot counters=0.
REQ-031: Reset mid-REQ drops the pending launch and all queued launches without emitting evt_o.

Configuration
REQ-032: With CGRA_KSCHED_PERF_EN defined, a 32-bit output wait_cycles_o counts cycles spent in ALLOC without allocation (saturating, reset 0).
REQ-033: Without CGRA_KSCHED_PERF_EN, wait_cycles_o is absent and no counter logic is present.

Structure
REQ-034: The FIFO entry typedef (ker_id, ncol, slot) and the FSM state enum live in cgra_pkg.
REQ-035: The FIFO is a sub-module named cgra_ksched_fifo.
REQ-036: Allocation, the FSM and the slot counters stay in the top module.

Verification
REQ-037: Push ker 3, ncol 2, slot 1 on idle block -> acc_req_o=4'b0011, ker_id_o=3 at cycle+2; ack -> col_busy_o=4'b0011; acc_end_i=4'b0011 -> evt_o=4'b0010 one cycle.
REQ-038: Running ncol 2 on cols 0-1, push ncol 3 -> held in ALLOC. Ending col 0 only -> still held. Ending col 1 -> acc_req_o=4'b0111.
REQ-039: Push 5 launches back-to-back while the controller withholds ack -> sub_ready_o low after 4 and q_count_o=4; then ack -> q_count_o=3, ready high.
REQ-040: Push ncol 0 and ncol 5 -> err_o pulses twice, q_count_o stays 0.
REQ-041: Two kernels on slots 0 and 2 ending in the same cycle -> evt_o=4'b0101.
REQ-042: Assert rst_ni low during REQ with 2 queued -> all outputs reach their reset values asynchronously and no evt_o follows.
